// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: N-channel, WIDTH-bit registered multiplexer with valid/ready
// handshakes on every input and on the output, and a one-deep output register.
// MODE=0 steers the channel named by select; MODE=1 arbitrates round-robin.
// Optional feature macro: MUX_ARB_PARITY_EN adds out_parity, the XOR
// reduction of out_data, registered alongside it.
module mux_arb_nx1 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2,
   parameter int unsigned MODE  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SEL_W-1:0]     select,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready,
   output logic [SEL_W-1:0]     out_sel
`ifdef MUX_ARB_PARITY_EN
   ,
   output logic                 out_parity
`endif
);

   localparam int unsigned LAST = N - 1;

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]     ptr_q,       ptr_d;
`ifdef MUX_ARB_PARITY_EN
   logic                 out_parity_q, out_parity_d;
`endif

   logic                 can_load_c;
   logic                 hit_c;
   logic                 xfer_c;
   logic [SEL_W-1:0]     grant_c;
   logic [SEL_W-1:0]     idx_c;
   logic [N-1:0]         in_ready_c;
   logic [WIDTH-1:0]     grant_data_c;

   // Pick the candidate channel and raise its ready when the output slot is free
   always_comb begin
      can_load_c = (!out_valid_q || out_ready) && !reset;
      hit_c      = 1'b0;
      grant_c    = '0;
      idx_c      = '0;
      in_ready_c = '0;
      if (MODE == 0) begin
         if (32'(select) < N) begin
            hit_c   = 1'b1;
            grant_c = select;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            idx_c = SEL_W'((32'(ptr_q) + i) % N);
            if (!hit_c && in_valid[idx_c]) begin
               hit_c   = 1'b1;
               grant_c = idx_c;
            end
         end
      end
      if (hit_c && can_load_c) begin
         in_ready_c[grant_c] = 1'b1;
      end
      xfer_c = hit_c && can_load_c && in_valid[grant_c];
   end

   // Data steering for the granted channel
   always_comb begin
      grant_data_c = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (32'(grant_c) == k) begin
            grant_data_c = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output register next-state: load on transfer, drain on consumer accept
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data_c;
         out_sel_d   = grant_c;
         if (MODE != 0) begin
            ptr_d = (32'(grant_c) == LAST) ? '0 : SEL_W'(grant_c + SEL_W'(1));
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
`ifdef MUX_ARB_PARITY_EN
      out_parity_d = ^out_data_d;
`endif
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef MUX_ARB_PARITY_EN
         out_parity_q <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef MUX_ARB_PARITY_EN
         out_parity_q <= out_parity_d;
`endif
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
`ifdef MUX_ARB_PARITY_EN
   assign out_parity = out_parity_q;
`endif

endmodule
